// File: rtl/power_pkg.sv
// Shared definitions for the power-domain sequencer: FSM encoding and default parameters.
package power_pkg;

    localparam int unsigned DEF_NUM_DOMAINS = 4;
    localparam int unsigned DEF_ISO_CYCLES  = 2;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISO_ON,
        ST_SAVE,
        ST_PWR_OFF,
        ST_PWR_ON,
        ST_RESTORE,
        ST_RST_REL,
        ST_ISO_OFF
    } seq_state_e;

endpackage

// File: rtl/pwr_rr_arbiter.sv
// Round-robin picker: first eligible domain at or after rr_ptr, wrapping around.
module pwr_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      rr_ptr,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/power_domain_sequencer.sv
// Sequences one power domain at a time through isolation, retention, switch and reset
// steps; round-robin arbitration picks the next domain whose request differs from its state.
module power_domain_sequencer
    import power_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int unsigned ISO_CYCLES  = DEF_ISO_CYCLES,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DOMAINS-1:0] req_on,
    input  logic [NUM_DOMAINS-1:0] pwr_ack,
    output logic [NUM_DOMAINS-1:0] pwr_switch_en,
    output logic [NUM_DOMAINS-1:0] iso_en,
    output logic [NUM_DOMAINS-1:0] ret_save,
    output logic [NUM_DOMAINS-1:0] ret_restore,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic [NUM_DOMAINS-1:0] domain_on,
    output logic                   busy,
    output logic [IDX_W-1:0]       active_idx,
    output logic [NUM_DOMAINS-1:0] timeout_err
);

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       idx_d;
    logic                   busy_d;
    logic [NUM_DOMAINS-1:0] switch_d, iso_d, rst_d, on_d, save_d, restore_d, err_d;
    logic [NUM_DOMAINS-1:0] eligible;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   iso_done, ack_expired;

    // A timed-out domain stays parked until its request is withdrawn.
    assign eligible    = (req_on ^ domain_on) & ~timeout_err;
    assign iso_done    = (32'(cnt_q) + 32'd1) >= ISO_CYCLES;
    assign ack_expired = (32'(cnt_q) + 32'd1) >= ACK_TIMEOUT;

    pwr_rr_arbiter #(
        .NUM_REQ (NUM_DOMAINS)
    ) u_arb (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        idx_d     = active_idx;
        busy_d    = busy;
        switch_d  = pwr_switch_en;
        iso_d     = iso_en;
        rst_d     = domain_rst;
        on_d      = domain_on;
        save_d    = '0;
        restore_d = '0;
        err_d     = timeout_err;
        case (state_q)
            ST_IDLE: begin
                err_d = timeout_err & req_on;
                if (grant_valid) begin
                    idx_d    = grant_idx;
                    busy_d   = 1'b1;
                    rr_ptr_d = IDX_W'((32'(grant_idx) + 32'd1) % NUM_DOMAINS);
                    if (req_on[grant_idx]) begin
                        state_d             = ST_PWR_ON;
                        switch_d[grant_idx] = 1'b1;
                    end else begin
                        state_d          = ST_ISO_ON;
                        iso_d[grant_idx] = 1'b1;
                    end
                end
            end
            ST_ISO_ON: begin
                if (iso_done) begin
                    state_d              = ST_SAVE;
                    save_d[active_idx]   = 1'b1;
                end
            end
            ST_SAVE: begin
                state_d              = ST_PWR_OFF;
                switch_d[active_idx] = 1'b0;
                rst_d[active_idx]    = 1'b1;
            end
            ST_PWR_OFF: begin
                // Either way the domain ends up off; a late ack only flags the error.
                if (!pwr_ack[active_idx] || ack_expired) begin
                    state_d            = ST_IDLE;
                    busy_d             = 1'b0;
                    on_d[active_idx]   = 1'b0;
                    if (pwr_ack[active_idx]) begin
                        err_d[active_idx] = 1'b1;
                    end
                end
            end
            ST_PWR_ON: begin
                if (pwr_ack[active_idx]) begin
                    state_d               = ST_RESTORE;
                    restore_d[active_idx] = 1'b1;
                end else if (ack_expired) begin
                    state_d              = ST_IDLE;
                    busy_d               = 1'b0;
                    switch_d[active_idx] = 1'b0;
                    iso_d[active_idx]    = 1'b1;
                    rst_d[active_idx]    = 1'b1;
                    on_d[active_idx]     = 1'b0;
                    err_d[active_idx]    = 1'b1;
                end
            end
            ST_RESTORE: begin
                state_d           = ST_RST_REL;
                rst_d[active_idx] = 1'b0;
            end
            ST_RST_REL: begin
                state_d = ST_ISO_OFF;
            end
            ST_ISO_OFF: begin
                if (iso_done) begin
                    state_d           = ST_IDLE;
                    busy_d            = 1'b0;
                    iso_d[active_idx] = 1'b0;
                    on_d[active_idx]  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Wait counter restarts on every state change and saturates otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            busy          <= 1'b0;
            active_idx    <= '0;
            timeout_err   <= '0;
            pwr_switch_en <= '1;
            domain_on     <= '1;
            iso_en        <= '0;
            domain_rst    <= '0;
            ret_save      <= '0;
            ret_restore   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            busy          <= busy_d;
            active_idx    <= idx_d;
            timeout_err   <= err_d;
            pwr_switch_en <= switch_d;
            domain_on     <= on_d;
            iso_en        <= iso_d;
            domain_rst    <= rst_d;
            ret_save      <= save_d;
            ret_restore   <= restore_d;
        end
    end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Self-checking bench: directed scenarios plus randomized requests against a
// sequence-level model (grant order, fixed per-direction latency, settled domain states).
module tb_power_domain_sequencer;

    localparam int unsigned ND  = 4;
    localparam int unsigned ISO = 2;
    localparam int unsigned TMO = 255;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [ND-1:0] req_on   = '1;
    logic [ND-1:0] pwr_ack  = '1;
    logic [ND-1:0] stuck_lo = '0;
    logic [ND-1:0] pwr_switch_en, iso_en, ret_save, ret_restore, domain_rst, domain_on, timeout_err;
    logic          busy;
    logic [1:0]    active_idx;

    int total = 0;
    int bad   = 0;

    // Sequence-level reference state
    logic [ND-1:0] m_on, m_terr;
    logic          m_busy, m_dir, m_tmo;
    logic [1:0]    m_idx, m_rr;
    int            m_rem;

    power_domain_sequencer #(
        .NUM_DOMAINS (ND),
        .ISO_CYCLES  (ISO),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_on        (req_on),
        .pwr_ack       (pwr_ack),
        .pwr_switch_en (pwr_switch_en),
        .iso_en        (iso_en),
        .ret_save      (ret_save),
        .ret_restore   (ret_restore),
        .domain_rst    (domain_rst),
        .domain_on     (domain_on),
        .busy          (busy),
        .active_idx    (active_idx),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Power switch: rail follows the enable one cycle later unless held down.
    always @(posedge clk) pwr_ack <= pwr_switch_en & ~stuck_lo;

    task automatic model_edge();
        logic [ND-1:0] elig;
        logic [1:0]    cand;
        logic          found;
        if (reset) begin
            m_on = '1; m_terr = '0; m_busy = 1'b0; m_idx = '0; m_rr = '0;
            m_rem = 0; m_dir = 1'b0; m_tmo = 1'b0;
            return;
        end
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy      = 1'b0;
                m_on[m_idx] = m_tmo ? 1'b0 : m_dir;
                if (m_tmo) m_terr[m_idx] = 1'b1;
            end
            return;
        end
        elig   = (req_on ^ m_on) & ~m_terr;
        m_terr = m_terr & req_on;
        found  = 1'b0;
        for (int k = 0; k < ND; k++) begin
            cand = 2'((int'(m_rr) + k) % ND);
            if (!found && elig[cand]) begin
                found = 1'b1;
                m_idx = cand;
            end
        end
        if (found) begin
            m_dir  = req_on[m_idx];
            m_busy = 1'b1;
            m_rr   = m_idx + 2'd1;
            m_tmo  = m_dir && stuck_lo[m_idx];
            // Edges after the grant edge until domain_on settles
            m_rem  = m_tmo ? int'(TMO) : (m_dir ? int'(5 + ISO - 1) : int'(ISO + 3));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_on = '1; stuck_lo = '0;
        do_reset();
        total++;
        if ({busy, active_idx, timeout_err} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b expected %b", {busy, active_idx, timeout_err}, 7'b0);
        end
        total++;
        if ({pwr_switch_en, domain_on, iso_en, domain_rst, ret_save, ret_restore} !== 24'hFF0000) begin
            bad++; $display("FAIL reset_domains: got %h expected ff0000",
                            {pwr_switch_en, domain_on, iso_en, domain_rst, ret_save, ret_restore});
        end
    endtask

    task automatic test_idle_hold();
        req_on = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if ({busy, domain_on} !== 5'b01111) begin
                bad++; $display("FAIL idle_hold_c%0d: got %b expected 01111", k, {busy, domain_on});
            end
        end
    endtask

    task automatic test_power_down();
        logic [5:0] want, got;
        req_on = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            step();
            want = {k <= ISO + 3, 1'b1, k == ISO + 1, k < ISO + 2, k >= ISO + 2, k < ISO + 4};
            got  = {busy, iso_en[0], ret_save[0], pwr_switch_en[0], domain_rst[0], domain_on[0]};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL power_down_c%0d busy/iso/save/sw/rst/on: got %b expected %b", k, got, want);
            end
        end
        total++;
        if (domain_on !== m_on) begin
            bad++; $display("FAIL power_down_model: got %b expected %b", domain_on, m_on);
        end
    endtask

    task automatic test_power_up();
        logic [5:0] want, got;
        req_on = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            step();
            want = {k <= ISO + 4, 1'b1, k == 3, k < 4, k < ISO + 5, k >= ISO + 5};
            got  = {busy, pwr_switch_en[0], ret_restore[0], domain_rst[0], iso_en[0], domain_on[0]};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL power_up_c%0d busy/sw/restore/rst/iso/on: got %b expected %b", k, got, want);
            end
        end
    endtask

    task automatic test_all_down();
        logic [1:0]    order[$];
        logic [ND-1:0] prev_sw;
        logic          prev_busy;
        do_reset();
        req_on    = 4'b0000;
        prev_sw   = pwr_switch_en;
        prev_busy = busy;
        for (int c = 0; c < 120 && !(order.size() == ND && !busy); c++) begin
            step();
            if (busy && !prev_busy) order.push_back(active_idx);
            total++;
            if ($countones(pwr_switch_en ^ prev_sw) > 1) begin
                bad++; $display("FAIL all_down_overlap_c%0d: got %b after %b expected one change", c, pwr_switch_en, prev_sw);
            end
            prev_sw   = pwr_switch_en;
            prev_busy = busy;
        end
        total++;
        if (order.size() != ND) begin
            bad++; $display("FAIL all_down_count: got %0d grants expected %0d", order.size(), ND);
        end
        for (int i = 0; i < order.size(); i++) begin
            total++;
            if (int'(order[i]) != i) begin
                bad++; $display("FAIL all_down_order%0d: got %0d expected %0d", i, order[i], i);
            end
        end
        total++;
        if ({busy, domain_on} !== {1'b0, m_on} || m_on !== 4'b0000) begin
            bad++; $display("FAIL all_down_final: got %b expected 00000 (model %b)", {busy, domain_on}, m_on);
        end
    endtask

    task automatic test_timeout();
        logic found;
        req_on   = 4'b1111;
        stuck_lo = 4'b0100;
        found    = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            found = busy && (active_idx == 2'd2);
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL timeout_grant: got no grant of domain 2 expected one");
        end
        for (int k = 2; k <= int'(TMO) + 1; k++) begin
            step();
            if (k == int'(TMO)) begin
                total++;
                if ({busy, timeout_err[2]} !== 2'b10) begin
                    bad++; $display("FAIL timeout_early: got %b expected 10", {busy, timeout_err[2]});
                end
            end
            if (k == int'(TMO) + 1) begin
                total++;
                if ({busy, timeout_err[2], pwr_switch_en[2], iso_en[2], domain_rst[2], domain_on[2]} !== 6'b010110) begin
                    bad++; $display("FAIL timeout_state: got %b expected 010110",
                                    {busy, timeout_err[2], pwr_switch_en[2], iso_en[2], domain_rst[2], domain_on[2]});
                end
            end
        end
        repeat (20) step();
        total++;
        if ({domain_on, timeout_err, m_on, m_terr} !== {4'b1011, 4'b0100, 4'b1011, 4'b0100}) begin
            bad++; $display("FAIL timeout_after: got on=%b err=%b expected on=1011 err=0100 (model %b %b)",
                            domain_on, timeout_err, m_on, m_terr);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (busy !== 1'b0) begin
                bad++; $display("FAIL timeout_no_regrant_c%0d: got busy=%b expected 0", c, busy);
            end
        end
        req_on   = 4'b1011;
        stuck_lo = '0;
        step();
        total++;
        if (timeout_err !== 4'b0000) begin
            bad++; $display("FAIL timeout_clear: got %b expected 0000", timeout_err);
        end
        req_on = 4'b1111;
        repeat (12) step();
        total++;
        if ({busy, domain_on} !== 5'b01111) begin
            bad++; $display("FAIL timeout_recover: got %b expected 01111", {busy, domain_on});
        end
    endtask

    task automatic test_reset_mid();
        req_on = 4'b1110;
        repeat (ISO + 2) step();
        total++;
        if ({busy, pwr_switch_en[0], domain_rst[0]} !== 3'b101) begin
            bad++; $display("FAIL reset_mid_pre: got %b expected 101", {busy, pwr_switch_en[0], domain_rst[0]});
        end
        reset = 1'b1;
        step();
        total++;
        if ({busy, active_idx, timeout_err, pwr_switch_en, domain_on, iso_en, domain_rst, ret_save, ret_restore}
                !== {7'b0, 24'hFF0000}) begin
            bad++; $display("FAIL reset_mid: got %h expected %h",
                            {busy, active_idx, timeout_err, pwr_switch_en, domain_on, iso_en, domain_rst, ret_save, ret_restore},
                            {7'b0, 24'hFF0000});
        end
        reset  = 1'b0;
        req_on = 4'b1111;
        repeat (3) step();
    endtask

    task automatic test_random();
        logic [ND-1:0] mask;
        stuck_lo = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) req_on = ND'($urandom);
            step();
            mask = m_busy ? ~(ND'(1) << m_idx) : '1;
            total++;
            if ({busy, active_idx} !== {m_busy, m_idx}) begin
                bad++; $display("FAIL rand_busy_c%0d: got %b expected %b", c, {busy, active_idx}, {m_busy, m_idx});
            end
            total++;
            if ({domain_on, timeout_err} !== {m_on, m_terr}) begin
                bad++; $display("FAIL rand_on_c%0d: got %b expected %b", c, {domain_on, timeout_err}, {m_on, m_terr});
            end
            total++;
            if ({pwr_switch_en & mask, iso_en & mask, domain_rst & mask}
                    !== {m_on & mask, ~m_on & mask, ~m_on & mask}) begin
                bad++; $display("FAIL rand_settled_c%0d: got sw=%b iso=%b rst=%b expected on=%b mask=%b",
                                c, pwr_switch_en, iso_en, domain_rst, m_on, mask);
            end
            total++;
            if (((ret_save | ret_restore) & mask) !== '0) begin
                bad++; $display("FAIL rand_pulse_c%0d: got save=%b restore=%b expected none outside %b",
                                c, ret_save, ret_restore, ~mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_power_down();
        test_power_up();
        test_all_down();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
